// File: rtl/text_line_buffer_if.sv
// Character-entry handshake for text_line_buffer.
// The master offers in_char with in_valid. The slave answers with in_ready.
// A character transfers on a rising clock edge where in_valid and in_ready are both 1.
interface text_line_buffer_if;
    logic       in_valid;
    logic [6:0] in_char;
    logic       in_ready;

    modport master (output in_valid, output in_char, input in_ready);
    modport slave  (input in_valid, input in_char, output in_ready);
endinterface

// File: rtl/text_line_buffer.sv
// Single-line text buffer feeding a glyph renderer.
// Characters are entered through a ready/valid interface. Printable codes append to the line,
// backspace removes the last character, and carriage return empties the line. Each cell holds
// one 7-bit ASCII code.
// The display side maps the scan position (pixel_x, pixel_y) combinationally to the cell
// underneath it, returning that cell's code and the cell's top-left pixel position.
// After reset, and after every carriage return, the block blanks the whole line with spaces,
// writing one cell per cycle. It does not accept characters while it is blanking.
// Optional feature: define TEXT_LINE_BUFFER_CURSOR_EN to show a blinking '_' cursor in the cell
// just past the end of the line.
module text_line_buffer #(
    parameter int unsigned MAX_CHARS = 32,
    parameter int unsigned TEXT_X    = 0,
    parameter int unsigned TEXT_Y    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    text_line_buffer_if.slave         in_if,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    output logic [6:0]                char_code,
    output logic [9:0]                text_x,
    output logic [9:0]                text_y,
    output logic [6:0]                length,
    output logic                      full
);

    localparam int unsigned     IdxW    = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam logic [6:0]      MaxLen  = 7'(MAX_CHARS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(MAX_CHARS - 1);
    localparam logic [9:0]      XBase   = 10'(TEXT_X);
    localparam logic [9:0]      YBase   = 10'(TEXT_Y);
    localparam logic [10:0]     YEnd    = 11'(TEXT_Y + 16);
    localparam logic [6:0]      Space   = 7'h20;
    localparam logic [6:0]      Bksp    = 7'h08;
    localparam logic [6:0]      Cr      = 7'h0D;

    typedef enum logic {StClear, StIdle} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] sweep_q, sweep_d;
    logic [6:0]      len_q, len_d;

    // Character store. It has no reset; the blanking sweep initialises it.
    logic [6:0]      mem [MAX_CHARS];
    logic            mem_we;
    logic [IdxW-1:0] mem_waddr;
    logic [6:0]      mem_wdata;

    logic [6:0]      cell_idx;
    logic [IdxW-1:0] rd_idx;
    logic            in_win;

    assign full   = (len_q == MaxLen);
    assign length = len_q;

    // State register: reset forces the blanking sweep to restart at cell 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StClear;
            sweep_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic: blanking sweep, and decoding of accepted characters.
    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        len_d          = len_q;
        mem_we         = 1'b0;
        mem_waddr      = sweep_q;
        mem_wdata      = Space;
        in_if.in_ready = 1'b0;
        unique case (state_q)
            StClear: begin
                mem_we = 1'b1;
                if (sweep_q == LastIdx) begin
                    state_d = StIdle;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + IdxW'(1);
                end
            end
            StIdle: begin
                in_if.in_ready = 1'b1;
                if (in_if.in_valid) begin
                    if (in_if.in_char >= 7'h20 && in_if.in_char <= 7'h7E) begin
                        // A printable character that arrives when the line is full is dropped.
                        if (!full) begin
                            mem_we    = 1'b1;
                            mem_waddr = IdxW'(len_q);
                            mem_wdata = in_if.in_char;
                            len_d     = len_q + 7'd1;
                        end
                    end else if (in_if.in_char == Bksp) begin
                        if (len_q != 7'd0) begin
                            mem_we    = 1'b1;
                            mem_waddr = IdxW'(len_q - 7'd1);
                            len_d     = len_q - 7'd1;
                        end
                    end else if (in_if.in_char == Cr) begin
                        len_d   = '0;
                        sweep_d = '0;
                        state_d = StClear;
                    end
                end
            end
            default: ;
        endcase
    end

    // Single write port. The display reads combinationally, so a read in the same cycle returns
    // the cell's old contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef TEXT_LINE_BUFFER_CURSOR_EN
    logic [24:0] blink_q;

    // Free-running blink counter. Its MSB is the cursor phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + 25'd1;
        end
    end
`endif

    // Display lookup: map the scan position to a cell, and return its code and origin.
    always_comb begin
        cell_idx  = 7'((pixel_x - XBase) >> 3);
        in_win    = (pixel_y >= YBase) && ({1'b0, pixel_y} < YEnd) &&
                    (pixel_x >= XBase) && (cell_idx < MaxLen);
        rd_idx    = IdxW'(cell_idx);
        char_code = Space;
        text_x    = XBase;
        text_y    = YBase;
        if (in_win) begin
            char_code = mem[rd_idx];
            text_x    = XBase + {cell_idx, 3'b000};
`ifdef TEXT_LINE_BUFFER_CURSOR_EN
            if (blink_q[24] && state_q == StIdle && !full && cell_idx == len_q) begin
                char_code = 7'h5F;
            end
`endif
        end
    end

endmodule

// File: tb/tb_text_line_buffer.sv
// Testbench for text_line_buffer.
// A behavioural line model advances on each rising edge. A compare process checks the DUT
// outputs against the model on every falling edge. Directed scenarios add literal expectations,
// and a long randomised phase follows them.
module tb_text_line_buffer;

    localparam int MAXC = 32;
    localparam int TX   = 40;
    localparam int TY   = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic [6:0] char_code;
    logic [9:0] text_x;
    logic [9:0] text_y;
    logic [6:0] length;
    logic       full;

    text_line_buffer_if in_if ();

    text_line_buffer #(
        .MAX_CHARS (MAXC),
        .TEXT_X    (TX),
        .TEXT_Y    (TY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (in_if),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .char_code (char_code),
        .text_x    (text_x),
        .text_y    (text_y),
        .length    (length),
        .full      (full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model of the line.
    // m_clear_left counts the blanking cycles that are still due; the line is usable when it is 0.
    int         m_len = 0;
    int         m_clear_left = MAXC;
    longint     m_blink = 0;
    logic [6:0] m_cells [MAXC];
    bit         m_known [MAXC];

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_len        = 0;
                m_clear_left = MAXC;
                m_blink      = 0;
            end else begin
                m_blink++;
                if (m_clear_left > 0) begin
                    m_cells[MAXC - m_clear_left] = 7'h20;
                    m_known[MAXC - m_clear_left] = 1'b1;
                    m_clear_left--;
                end else if (in_if.in_valid) begin
                    int c;
                    c = int'(in_if.in_char);
                    if (c >= 32 && c <= 126) begin
                        if (m_len < MAXC) begin
                            m_cells[m_len] = 7'(c);
                            m_known[m_len] = 1'b1;
                            m_len++;
                        end
                    end else if (c == 8) begin
                        if (m_len > 0) begin
                            m_len--;
                            m_cells[m_len] = 7'h20;
                        end
                    end else if (c == 13) begin
                        m_len        = 0;
                        m_clear_left = MAXC;
                    end
                end
            end
        end
    end

    // Compare process: checks the DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            int px, py, idx, exp_code;
            bit inwin, known_code;
            @(negedge clk);
            check("in_ready", int'(in_if.in_ready), (!reset && m_clear_left == 0) ? 1 : 0);
            check("length", int'(length), m_len);
            check("full", int'(full), (m_len == MAXC) ? 1 : 0);
            px    = int'(pixel_x);
            py    = int'(pixel_y);
            idx   = (px - TX) / 8;
            inwin = (py >= TY) && (py < TY + 16) && (px >= TX) && (idx < MAXC);
            check("text_y", int'(text_y), TY);
            check("text_x", int'(text_x), inwin ? TX + 8 * idx : TX);
            known_code = 1'b1;
            exp_code   = 32;
            if (inwin) begin
                known_code = (m_clear_left == 0) && m_known[idx];
                exp_code   = int'(m_cells[idx]);
`ifdef TEXT_LINE_BUFFER_CURSOR_EN
                if (((m_blink >> 24) & 1) == 1 && m_clear_left == 0 && m_len < MAXC &&
                    idx == m_len) begin
                    exp_code = 32'h5F;
                end
`endif
            end
            if (known_code) begin
                check("char_code", int'(char_code), exp_code);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] c);
        int n = 0;
        while (!in_if.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_if.in_ready) begin
            check("ready_wait", int'(in_if.in_ready), 1);
        end
        in_if.in_valid = 1'b1;
        in_if.in_char  = c;
        tick();
        in_if.in_valid = 1'b0;
    endtask

    task automatic peek(input string name, input int x, input int y, input int exp_code,
                        input int exp_tx);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        #1;
        check({name, "_code"}, int'(char_code), exp_code);
        check({name, "_tx"}, int'(text_x), exp_tx);
        check({name, "_ty"}, int'(text_y), TY);
    endtask

    task automatic expect_sweep(input string name);
        for (int i = 0; i < MAXC; i++) begin
            check({name, "_busy"}, int'(in_if.in_ready), 0);
            tick();
        end
        check({name, "_ready"}, int'(in_if.in_ready), 1);
    endtask

    task automatic scan_blank(input string name);
        for (int i = 0; i < MAXC; i++) begin
            peek(name, TX + 8 * i + (i % 8), TY + (i % 16), 32'h20, TX + 8 * i);
        end
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_char  = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Initial blanking after reset.
        expect_sweep("rst_sweep");
        check("rst_len", int'(length), 0);
        scan_blank("rst_blank");

        // Enter "HI".
        send(7'h48);
        send(7'h49);
        check("hi_len", int'(length), 2);
        peek("hi_cell1", TX + 9, TY + 3, 32'h49, TX + 8);
        peek("hi_cell0", TX + 2, TY + 15, 32'h48, TX);

        // Carriage return at length 5.
        send(7'h41);
        send(7'h42);
        send(7'h43);
        check("cr_len5", int'(length), 5);
        send(7'h0D);
        check("cr_len0", int'(length), 0);
        expect_sweep("cr_sweep");
        scan_blank("cr_blank");

        // Fill the line, then overflow it by one.
        for (int i = 0; i < MAXC; i++) begin
            send(7'(8'h41 + (i % 26)));
        end
        check("fill_full", int'(full), 1);
        check("fill_len", int'(length), MAXC);
        send(7'h21);
        check("ovf_len", int'(length), MAXC);
        check("ovf_full", int'(full), 1);
        peek("ovf_last", TX + 8 * 31 + 7, TY, 32'h46, TX + 8 * 31);
        peek("ovf_edge", TX + 8 * MAXC, TY, 32'h20, TX);
        send(7'h0D);
        expect_sweep("ovf_sweep");

        // Backspace.
        send(7'h08);
        check("bs_empty", int'(length), 0);
        send(7'h41);
        check("bs_a", int'(length), 1);
        send(7'h08);
        check("bs_len", int'(length), 0);
        peek("bs_cell0", TX + 4, TY + 8, 32'h20, TX);

        // Reset in the middle of a blanking sweep.
        send(7'h0D);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("midrst_len", int'(length), 0);
        check("midrst_ready", int'(in_if.in_ready), 0);
        reset = 1'b0;
        expect_sweep("midrst_sweep");
        send(7'h5A);
        peek("z_cell0", TX, TY, 32'h5A, TX);
        peek("below_win", TX, TY + 16, 32'h20, TX);
        peek("above_win", TX + 3, TY - 1, 32'h20, TX);
        peek("left_win", TX - 1, TY + 5, 32'h20, TX);

        // Randomised phase, checked each cycle by the compare process.
        for (int n = 0; n < 4000; n++) begin
            int r;
            in_if.in_valid = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (r < 75) begin
                in_if.in_char = 7'($urandom_range(32, 126));
            end else if (r < 87) begin
                in_if.in_char = 7'h08;
            end else if (r < 89) begin
                in_if.in_char = 7'h0D;
            end else begin
                in_if.in_char = 7'($urandom_range(0, 127));
            end
            pixel_x = 10'($urandom_range(0, TX + 8 * MAXC + 20));
            pixel_y = 10'($urandom_range(TY - 4, TY + 20));
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                tick();
                tick();
                reset = 1'b0;
            end
            tick();
        end
        in_if.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_line_buffer.md
TEXT_LINE_BUFFER -- requirements
Module: text_line_buffer

Interface
REQ-001 Parameter MAX_CHARS, default 32, meaning line capacity in characters; legal range 1..80.
REQ-002 Parameter TEXT_X, default 0, meaning left pixel column of the line.
REQ-003 Parameter TEXT_Y, default 0, meaning top pixel row of the line.
REQ-004 Port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  meaning in_char holds a character offered for entry.
REQ-007 Port in_char  input  7  meaning 7-bit ASCII character offered.
REQ-008 Port in_ready  output  1  meaning the block accepts in_char this cycle.
REQ-009 Port pixel_x  input  10  meaning current scan column.
REQ-010 Port pixel_y  input  10  meaning current scan row.
REQ-011 Port char_code  output  7  meaning ASCII code of the cell under the pixel, fed to the glyph renderer.
REQ-012 Port text_x  output  10  meaning left pixel column of that cell.
REQ-013 Port text_y  output  10  meaning top pixel row of that cell.
REQ-014 Port length  output  7  meaning number of characters currently in the line.
REQ-015 Port full  output  1  meaning length equals MAX_CHARS.

Function
REQ-016 Storage SHALL be a MAX_CHARS x 7 array with no reset, written one cell per clock.
REQ-017 State machine SHALL have two states: CLEAR and IDLE.
REQ-018 In CLEAR, a sweep index SHALL write 0x20 to cells 0..MAX_CHARS-1, one per cycle, then enter IDLE; CLEAR lasts exactly MAX_CHARS cycles.
REQ-019 in_ready SHALL be 1 in IDLE and 0 in CLEAR; a transfer occurs on a rising edge with in_valid and in_ready both 1.
REQ-020 Accepted printable char (0x20..0x7E) SHALL be written at cell[length] and length incremented, if not full; if full it is consumed and discarded.
REQ-021 Accepted 0x08 (backspace) SHALL write 0x20 at cell[length-1] and decrement length, if length>0; at length 0 it is consumed with no effect.
REQ-022 Accepted 0x0D SHALL set length to 0 and enter CLEAR on the next cycle.
REQ-023 Every other accepted code SHALL be consumed and ignored.
REQ-024 full SHALL equal (length == MAX_CHARS) combinationally.
REQ-025 Display lookup SHALL be combinational, zero latency.
REQ-026 The pixel is in-window when TEXT_Y <= pixel_y < TEXT_Y+16, pixel_x >= TEXT_X, and idx = (pixel_x - TEXT_X) >> 3 < MAX_CHARS.
REQ-027 In-window: char_code = cell[idx], text_x = TEXT_X + 8*idx, text_y = TEXT_Y.
REQ-028 Out-of-window: char_code = 0x20, text_x = TEXT_X, text_y = TEXT_Y.
REQ-029 A write and a display read of the same cell in one cycle SHALL return the old contents.

Reset
REQ-030 While reset is high: state = CLEAR, sweep index = 0, length = 0, in_ready = 0.
REQ-031 After reset deasserts, the block SHALL sweep MAX_CHARS cycles, then set in_ready = 1.
REQ-032 Reset asserted mid-sweep or mid-transfer SHALL restart the sweep from cell 0.

Configuration
REQ-033 Macro TEXT_LINE_BUFFER_CURSOR_EN SHALL enable a blinking cursor.
REQ-034 When defined: a 25-bit free-running counter is reset to 0. Its MSB is the blink phase. While blink phase is 1, state is IDLE, and full is 0, the in-window cell idx == length shows char_code 0x5F.
REQ-035 When undefined: no counter exists, and that cell shows its stored contents.

Verification
REQ-036 Reset then release -> in_ready = 0 for 32 cycles, then 1; length = 0; all 32 cells read 0x20 via pixel scan.
REQ-037 Send 'H','I' (0x48, 0x49) -> length = 2; pixel (TEXT_X+9, TEXT_Y+3) gives char_code 0x49, text_x = TEXT_X+8.
REQ-038 Send 33 printable chars -> full = 1 after the 32nd; the 33rd is accepted and discarded; length = 32.
REQ-039 Send 0x08 at length 0 -> length stays 0; send 'A' then 0x08 -> length = 0 and cell 0 reads 0x20.
REQ-040 Send 0x0D with length 5 -> length = 0; in_ready = 0 for 32 cycles; all cells read 0x20 afterwards.
REQ-041 Assert reset during a 0x0D sweep at index 10 -> after release, a full 32-cycle sweep occurs; pixel_y = TEXT_Y+16 gives char_code 0x20.
